// File: rtl/nrf_cfg_sequencer.sv
// nRF24L01 power-up configurator: writes a fixed register table over a byte-wide SPI engine, then reads STATUS.
// Optional NRF_CFG_READBACK_EN: read back and verify each register after writing it.
module nrf_cfg_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       spi_busy,
    input  logic [7:0] spi_rx_data,
    output logic [7:0] spi_tx_data,
    output logic       spi_start,
    output logic       spi_csn,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] status
);

`ifdef NRF_CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [3:0] {
        IDLE, CSN_LOW, SEND, WAIT_RISE, WAIT_FALL, CSN_HIGH, GAP, STATUS, DONE
    } state_t;

    typedef enum logic [1:0] {PH_WRITE, PH_READ, PH_NOP} phase_t;

    state_t          state, state_next;
    phase_t          phase, phase_next;
    logic [2:0]      reg_idx, reg_idx_next;
    logic            byte_idx;
    logic [CW-1:0]   cnt;
    logic [7:0]      rx_byte;
    logic            byte_done, last_byte, timeout_hit, mismatch, gap_over;

    function automatic logic [7:0] reg_addr(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h00;
            3'd1:    return 8'h01;
            3'd2:    return 8'h03;
            3'd3:    return 8'h04;
            3'd4:    return 8'h05;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] reg_data(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h0E;
            3'd1:    return 8'h3F;
            3'd2:    return 8'h03;
            3'd3:    return 8'h2F;
            3'd4:    return 8'h4C;
            default: return 8'h07;
        endcase
    endfunction

    // Byte 0 is the command, byte 1 the payload; the NOP transaction is a single 0xFF.
    function automatic logic [7:0] tx_byte(input phase_t ph, input logic [2:0] i, input logic b);
        case (ph)
            PH_WRITE: return b ? reg_data(i) : (8'h20 | reg_addr(i));
            PH_READ:  return b ? 8'hFF : reg_addr(i);
            default:  return 8'hFF;
        endcase
    endfunction

    assign byte_done   = (state == WAIT_FALL) && !spi_busy;
    assign last_byte   = (phase == PH_NOP) || byte_idx;
    assign timeout_hit = (state == WAIT_RISE) && !spi_busy && (cnt == CW'(TIMEOUT - 1));
    assign mismatch    = READBACK && byte_done && (phase == PH_READ) && byte_idx &&
                         (spi_rx_data != reg_data(reg_idx));
    // CSN_HIGH is the first of the GAP_CYCLES high cycles, so GAP covers the rest.
    assign gap_over    = ((state == CSN_HIGH) && !error && (GAP_CYCLES == 1)) ||
                         ((state == GAP) && (cnt == CW'(GAP_CYCLES - 2)));

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign spi_start = (state == SEND) && !spi_busy;
    assign spi_csn   = !((state == CSN_LOW) || (state == SEND) ||
                         (state == WAIT_RISE) || (state == WAIT_FALL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= PH_WRITE;
            reg_idx <= 3'd0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            reg_idx <= reg_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        reg_idx_next = reg_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = CSN_LOW;
                    phase_next   = PH_WRITE;
                    reg_idx_next = 3'd0;
                end
            end
            CSN_LOW:   state_next = SEND;
            SEND:      if (!spi_busy) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (spi_busy)         state_next = WAIT_FALL;
                else if (timeout_hit) state_next = DONE;
            end
            WAIT_FALL: begin
                if (byte_done) begin
                    if (mismatch)              state_next = CSN_HIGH;
                    else if (!last_byte)       state_next = SEND;
                    else if (phase == PH_NOP)  state_next = STATUS;
                    else                       state_next = CSN_HIGH;
                end
            end
            CSN_HIGH: begin
                if (error)                 state_next = DONE;
                else if (GAP_CYCLES != 1)  state_next = GAP;
            end
            STATUS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = state;
        endcase
        if (gap_over) begin
            state_next = CSN_LOW;
            if (READBACK && (phase == PH_WRITE)) begin
                phase_next = PH_READ;
            end else if (reg_idx == 3'd5) begin
                phase_next = PH_NOP;
            end else begin
                reg_idx_next = reg_idx + 3'd1;
                phase_next   = PH_WRITE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx    <= 1'b0;
            cnt         <= '0;
            rx_byte     <= 8'h00;
            spi_tx_data <= 8'h00;
            status      <= 8'h00;
            error       <= 1'b0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if ((state == WAIT_RISE) || (state == GAP))
                cnt <= cnt + 1'b1;
            if ((state == IDLE) && start)
                error <= 1'b0;
            if (timeout_hit || mismatch)
                error <= 1'b1;
            if (state == CSN_LOW) begin
                byte_idx    <= 1'b0;
                spi_tx_data <= tx_byte(phase, reg_idx, 1'b0);
            end
            if (byte_done) begin
                rx_byte <= spi_rx_data;
                if (!last_byte) begin
                    byte_idx    <= 1'b1;
                    spi_tx_data <= tx_byte(phase, reg_idx, 1'b1);
                end
            end
            if (state == STATUS)
                status <= rx_byte;
        end
    end

endmodule

// File: tb/tb_nrf_cfg_sequencer.sv
// Self-checking bench for nrf_cfg_sequencer: behavioural nRF24L01/SPI-engine model plus a table-driven expected byte stream.
module tb_nrf_cfg_sequencer;
    localparam int GAP    = 4;
    localparam int TMO    = 1023;
    localparam int BUDGET = 4000;
    localparam int NONE   = 255;
`ifdef NRF_CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, spi_busy;
    logic [7:0] spi_rx_data, spi_tx_data, status;
    logic       spi_start, spi_csn, busy, done, error;

    nrf_cfg_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .spi_busy(spi_busy),
        .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data), .spi_start(spi_start),
        .spi_csn(spi_csn), .busy(busy), .done(done), .error(error), .status(status)
    );

    always #5 clk = ~clk;

    int error_count = 0;
    int check_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // SPI engine + radio model knobs
    bit         model_dead = 1'b0;
    int         busy_len = 16;
    logic [7:0] status_val = 8'h0E;
    int         corrupt_addr = NONE;
    logic [7:0] mem [0:31];
    logic [7:0] rx_next = 8'h00;
    logic [7:0] cmd_byte = 8'h00;
    int         byte_pos = 0;
    int         busy_cnt;
    bit         start_seen = 1'b0;

    // Observation state
    logic [7:0] tx_log[$];
    int         gap_runs[$];
    int         high_run = 0, idle_run = 0, last_idle = 0;
    int         done_count = 0, protocol_err = 0, cycle = 0;
    int         last_start_cycle = 0, done_cycle = 0;
    bit         prev_start = 1'b0;
    logic       prev_csn = 1'b1;

    // Reference expectations
    logic [7:0] exp_bytes[$];
    int         exp_trans;
    bit         exp_abort;
    logic [7:0] exp_status = 8'h00;

    always @(negedge clk) begin
        cycle++;
        if (spi_csn) byte_pos = 0;
        start_seen = spi_start;
        if (spi_start) begin
            tx_log.push_back(spi_tx_data);
            last_start_cycle = cycle;
            if (byte_pos == 0) begin
                cmd_byte = spi_tx_data;
                rx_next  = status_val;
            end else if (cmd_byte[7:5] == 3'b001) begin
                mem[cmd_byte[4:0]] = spi_tx_data;
                rx_next = status_val;
            end else if (cmd_byte < 8'h20) begin
                rx_next = (int'(cmd_byte) == corrupt_addr) ? 8'h3E : mem[cmd_byte[4:0]];
            end else begin
                rx_next = status_val;
            end
            byte_pos++;
        end
        if (spi_start && prev_start) protocol_err++;
        if ((spi_csn !== prev_csn) && spi_busy) protocol_err++;
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        if (!busy) begin
            high_run = 0;
            idle_run++;
        end else begin
            if (idle_run > 0) last_idle = idle_run;
            idle_run = 0;
            if (spi_csn) high_run++;
            else begin
                if (high_run > 0) gap_runs.push_back(high_run);
                high_run = 0;
            end
        end
        prev_start = spi_start;
        prev_csn   = spi_csn;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_busy    <= 1'b0;
            busy_cnt    <= 0;
            spi_rx_data <= 8'h00;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                spi_busy    <= 1'b0;
                spi_rx_data <= rx_next;
            end
        end else if (start_seen && !model_dead) begin
            spi_busy <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    task automatic buildExpected(input int corrupt, input bit dead);
        logic [7:0] addr_tbl [0:5] = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
        logic [7:0] data_tbl [0:5] = '{8'h0E, 8'h3F, 8'h03, 8'h2F, 8'h4C, 8'h07};
        exp_bytes.delete();
        exp_trans = 0;
        exp_abort = dead;
        if (dead) begin
            exp_bytes.push_back(8'h20);
            exp_trans = 1;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            exp_bytes.push_back(8'h20 | addr_tbl[i]);
            exp_bytes.push_back(data_tbl[i]);
            exp_trans++;
            if (READBACK) begin
                exp_bytes.push_back(addr_tbl[i]);
                exp_bytes.push_back(8'hFF);
                exp_trans++;
                if (int'(addr_tbl[i]) == corrupt) begin
                    exp_abort = 1'b1;
                    break;
                end
            end
        end
        if (!exp_abort) begin
            exp_bytes.push_back(8'hFF);
            exp_trans++;
        end
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic checkSequence(input int d0);
        checkOutput("done_pulses", done_count - d0, 1);
        checkOutput("tx_count", tx_log.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i < tx_log.size())
                checkOutput($sformatf("tx_byte[%0d]", i), tx_log[i], exp_bytes[i]);
        checkOutput("gap_count", gap_runs.size(), exp_trans - 1);
        foreach (gap_runs[i]) checkOutput($sformatf("gap_len[%0d]", i), gap_runs[i], GAP);
        checkOutput("error", 32'(error), 32'(exp_abort));
        checkOutput("status", status, exp_status);
        checkOutput("busy_after", 32'(busy), 0);
        checkOutput("csn_after", 32'(spi_csn), 1);
        checkOutput("protocol", protocol_err, 0);
    endtask

    task automatic applyStimulus(input int hold, input int corrupt, input bit dead);
        int d0;
        model_dead   = dead;
        corrupt_addr = corrupt;
        buildExpected(corrupt, dead);
        tx_log.delete();
        gap_runs.delete();
        d0 = done_count;
        @(negedge clk);
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(2, 10)) @(negedge clk);
        if (busy) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitDone("done_seen");
        repeat (4) @(negedge clk);
        if (!exp_abort) exp_status = status_val;
        checkSequence(d0);
        if (dead) checkOutput("timeout_len", done_cycle - last_start_cycle, TMO + 1);
        model_dead = 1'b0;
    endtask

    initial begin
        int d0, idx, sz;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_csn", 32'(spi_csn), 1);
        checkOutput("rst_start", 32'(spi_start), 0);
        checkOutput("rst_tx", spi_tx_data, 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_error", 32'(error), 0);
        checkOutput("rst_status", status, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] nominal sequence");
        busy_len = 16;
        status_val = 8'h0E;
        applyStimulus(1, NONE, 1'b0);

        $display("[TB] randomized sequences");
        for (int k = 0; k < 6; k++) begin
            busy_len   = $urandom_range(1, 20);
            status_val = 8'($urandom_range(0, 255));
            applyStimulus($urandom_range(1, 10), NONE, 1'b0);
        end

        if (READBACK) begin
            $display("[TB] readback mismatch on register 0x01");
            busy_len = $urandom_range(1, 20);
            applyStimulus(1, 1, 1'b0);
            applyStimulus(2, NONE, 1'b0);
        end

        $display("[TB] timeout with silent SPI engine");
        applyStimulus(3, NONE, 1'b1);
        status_val = 8'($urandom_range(0, 255));
        applyStimulus(1, NONE, 1'b0);

        $display("[TB] start held high");
        busy_len = 2;
        buildExpected(NONE, 1'b0);
        tx_log.delete();
        d0 = done_count;
        start = 1'b1;
        waitDone("held_done1");
        @(negedge clk);
        last_idle = 0;
        sz = 0;
        while (!done && sz < BUDGET) begin
            @(negedge clk);
            sz++;
        end
        waitDone("held_done2");
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("held_idle_gap", 32'(last_idle >= 1), 1);
        checkOutput("held_pulses", done_count - d0, 2);
        checkOutput("held_tx_count", tx_log.size(), 2 * exp_bytes.size());
        checkOutput("held_error", 32'(error), 0);
        exp_status = status_val;

        $display("[TB] reset during data byte of register 0x03");
        busy_len = 16;
        tx_log.delete();
        idx = READBACK ? 9 : 5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sz = 0;
        while (tx_log.size() <= idx && sz < BUDGET) begin
            @(negedge clk);
            sz++;
        end
        checkOutput("rst_reached_byte", 32'(tx_log.size() > idx), 1);
        if (tx_log.size() > idx) checkOutput("rst_byte_val", tx_log[idx], 8'h03);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_csn", 32'(spi_csn), 1);
        checkOutput("mid_rst_start", 32'(spi_start), 0);
        checkOutput("mid_rst_tx", spi_tx_data, 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        checkOutput("mid_rst_error", 32'(error), 0);
        checkOutput("mid_rst_status", status, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_status = 8'h00;
        sz = tx_log.size();
        repeat (40) @(negedge clk);
        checkOutput("post_rst_quiet", tx_log.size(), sz);
        checkOutput("post_rst_busy", 32'(busy), 0);
        protocol_err = 0;
        status_val = 8'hA5;
        applyStimulus(1, NONE, 1'b0);

        $display("[TB] Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/nrf_cfg_sequencer.md
NRF_CFG_SEQUENCER -- requirements
Module: nrf_cfg_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: idle cycles with spi_csn high between transactions (range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for spi_busy to rise after a spi_start pulse.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level request; sampled only in IDLE to begin the configuration sequence.
REQ-006 spi_busy  input  1  high while the SPI byte engine is shifting.
REQ-007 spi_rx_data  input  8  byte received by the SPI engine; valid when spi_busy falls.
REQ-008 spi_tx_data  output  8  byte presented to the SPI engine; held stable from spi_start until spi_busy falls.
REQ-009 spi_start  output  1  single-cycle pulse launching one byte transfer.
REQ-010 spi_csn  output  1  nRF24L01 chip select, active low.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  single-cycle pulse when the sequence ends, with or without error.
REQ-013 error  output  1  sticky; set on timeout or readback mismatch; cleared on the next accepted start.
REQ-014 status  output  8  nRF24L01 STATUS byte captured by the final NOP transaction.

Function
REQ-015 SHALL write six registers, in this order, from an internal table (address=data): 0x00=0x0E, 0x01=0x3F, 0x03=0x03, 0x04=0x2F, 0x05=0x4C, 0x06=0x07.
REQ-016 Each write transaction SHALL consist of: spi_csn low, command byte 0x20|addr, data byte, spi_csn high, then GAP_CYCLES cycles with spi_csn high.
REQ-017 State machine SHALL implement the states IDLE, CSN_LOW, SEND, WAIT_RISE, WAIT_FALL, CSN_HIGH, GAP, STATUS and DONE.
- Byte sub-sequence SEND -> WAIT_RISE -> WAIT_FALL is shared by all bytes; a byte index selects what follows it.
REQ-018 IDLE with start=1 SHALL move to CSN_LOW on the next edge; spi_csn SHALL fall in that same cycle.
REQ-019 SEND SHALL be entered one cycle after CSN_LOW, and SHALL pulse spi_start only when spi_busy=0; otherwise it SHALL stall in SEND.
REQ-020 A byte SHALL be considered complete on the first cycle that spi_busy=0 after spi_busy was seen high (WAIT_RISE then WAIT_FALL).
- spi_rx_data SHALL be sampled on that cycle.
REQ-021 spi_busy staying low for TIMEOUT cycles in WAIT_RISE SHALL set error, force spi_csn high, and go to DONE.
REQ-022 After the sixth write, the block SHALL perform a one-byte transaction sending 0xFF (NOP) and load status with the received byte.
REQ-023 DONE SHALL pulse done for one cycle and return to IDLE; start held high SHALL begin a new sequence only after one IDLE cycle.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 spi_start SHALL never be high for two consecutive cycles, and spi_csn SHALL never change while spi_busy=1.

Reset
REQ-026 Reset SHALL force the outputs to: state IDLE, spi_csn=1, spi_start=0, spi_tx_data=0x00, busy=0, done=0, error=0, status=0x00; the table index, byte index and counters SHALL be cleared.
REQ-027 Reset asserted mid-transaction SHALL raise spi_csn immediately (asynchronously); after release, the sequence SHALL restart only on a new start.

Configuration
REQ-028 With macro NRF_CFG_READBACK_EN defined, each write SHALL be followed, after the gap, by a readback transaction.
- Readback: command 0x00|addr, then 0xFF; the second received byte SHALL be compared with the written data.
- On mismatch: set error, skip the remaining registers, skip the STATUS read, go to DONE.
REQ-029 Without NRF_CFG_READBACK_EN, no readback SHALL occur, and error SHALL be set by timeout only.

Verification
REQ-030 SPI model (busy rises 1 cycle after start, lasts 16 cycles, rx=0x0E), start pulse -> MOSI byte stream 20 0E 21 3F 23 03 24 2F 25 4C 26 07 FF; status=0x0E; one done pulse; error=0.
REQ-031 Check the gap between transactions -> spi_csn high for exactly 4 cycles with GAP_CYCLES=4.
REQ-032 Model never raises spi_busy -> error=1 after 1023 cycles in WAIT_RISE; spi_csn=1; done pulses once.
REQ-033 Reset asserted during the data byte of register 0x03 -> spi_csn=1 and all outputs at reset values the same cycle; no activity until the next start.
REQ-034 NRF_CFG_READBACK_EN defined, model returns 0x3E on readback of 0x01 -> error=1, done pulse, no writes to 0x03..0x06.
REQ-035 start held high continuously -> sequences separated by at least one IDLE cycle; start pulsed during busy -> ignored.
